// File: rtl/div_unit.sv
// MIPS DIV/DIVU iterative radix-2 restoring divider for the execute stage.
// Latency: 33 cycles from start to result_valid (1 cycle for divide-by-zero).
// Backpressure: busy holds the pipeline during CALC; start is ignored while busy.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        cancel,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  iter_cnt;
  // Partial remainder; bit 32 is always zero between iterations but keeps
  // the trial subtraction honest.
  logic [32:0] rem;
  // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
  logic [31:0] quo;
  logic [31:0] dvs_mag;
  logic        qneg;
  logic        rneg;

  logic        accept;
  logic        dvs_zero;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [33:0] trial;
  logic        trial_neg;
  logic [32:0] rem_next;
  logic [31:0] quo_next;
  logic        last_iter;
  logic [31:0] q_fixed;
  logic [31:0] r_fixed;

  // Operand capture decode and one restoring-division step.
  always_comb begin
    accept    = (state != ST_CALC) && start && !cancel;
    dvs_zero  = (divisor == 32'd0);
    a_neg     = signed_div & dividend[31];
    b_neg     = signed_div & divisor[31];
    // Two's-complement negate wraps, so abs(0x8000_0000) stays 0x8000_0000,
    // which is exactly its unsigned magnitude.
    a_mag     = a_neg ? (~dividend + 32'd1) : dividend;
    b_mag     = b_neg ? (~divisor + 32'd1) : divisor;
    trial     = {rem, quo[31]} - {2'b00, dvs_mag};
    trial_neg = trial[33];
    rem_next  = trial_neg ? {rem[31:0], quo[31]} : trial[32:0];
    quo_next  = {quo[30:0], ~trial_neg};
    last_iter = (iter_cnt == 5'd31);
    q_fixed   = qneg ? (~quo_next + 32'd1) : quo_next;
    r_fixed   = rneg ? (~rem_next[31:0] + 32'd1) : rem_next[31:0];
  end

  // Control FSM: state, iteration counter, busy and the result strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      iter_cnt     <= 5'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else if (cancel) begin
      state        <= ST_IDLE;
      iter_cnt     <= 5'd0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          iter_cnt <= 5'd0;
          if (start) begin
            if (dvs_zero) begin
              state        <= ST_DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              state        <= ST_CALC;
              busy         <= 1'b1;
              result_valid <= 1'b0;
            end
          end else begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        ST_CALC: begin
          iter_cnt <= iter_cnt + 5'd1;
          if (last_iter) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            state        <= ST_CALC;
            busy         <= 1'b1;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          iter_cnt     <= 5'd0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  // Iteration datapath: load magnitudes on accept, then shift/subtract in CALC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem     <= 33'd0;
      quo     <= 32'd0;
      dvs_mag <= 32'd0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
    end else if (accept) begin
      rem     <= 33'd0;
      quo     <= a_mag;
      dvs_mag <= b_mag;
      qneg    <= a_neg ^ b_neg;
      rneg    <= a_neg;
    end else if ((state == ST_CALC) && !cancel) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

  // Result registers: written only on entry to DONE, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else if (accept && dvs_zero) begin
      lo_out <= 32'hFFFF_FFFF;
      hi_out <= dividend;
    end else if ((state == ST_CALC) && last_iter && !cancel) begin
      lo_out <= q_fixed;
      hi_out <= r_fixed;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, randomized DIV/DIVU
// against an arithmetic reference, cancel, reset and back-to-back scenarios.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        cancel;
  logic        busy;
  logic        result_valid;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks;
  int errors;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .cancel       (cancel),
    .busy         (busy),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIPS semantics from plain integer arithmetic: truncating division,
  // remainder takes the dividend's sign; divide-by-zero fixed pattern.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi);
    longint sa, sb, q, r;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      return;
    end
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q  = sa / sb;
    r  = sa % sb;
    lo = q[31:0];
    hi = r[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide from the current cycle and watch until result_valid.
  // rvc = cycles after the start cycle at which result_valid was seen (-1 if never),
  // bcnt = cycles with busy high up to and including that cycle.
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int bcnt, output int rvc,
                        output logic [31:0] lo, output logic [31:0] hi);
    bcnt = 0;
    rvc  = -1;
    lo   = 32'd0;
    hi   = 32'd0;
    signed_div = s;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    signed_div = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 60; k++) begin
      if (busy) bcnt++;
      if (result_valid) begin
        rvc = k;
        lo  = lo_out;
        hi  = hi_out;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b rv=%b hi=%h lo=%h, want 0 0 0 0", busy, result_valid, hi_out, lo_out);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b rv=%b, want 0 0", busy, result_valid);
    end
  endtask

  task automatic test_directed();
    logic        ts[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] ta[5] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] tb[5] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] tlo[5] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] thi[5] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
    int bcnt, rvc;
    logic [31:0] lo, hi;
    for (int i = 0; i < 5; i++) begin
      do_div(ts[i], ta[i], tb[i], bcnt, rvc, lo, hi);
      checks++;
      if (rvc !== 33 || bcnt !== 32) begin
        errors++;
        $display("FAIL directed_timing[%0d]: rv_cycle=%0d busy_cycles=%0d, want 33 32", i, rvc, bcnt);
      end
      checks++;
      if (lo !== tlo[i] || hi !== thi[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: lo=%h hi=%h, want lo=%h hi=%h", i, lo, hi, tlo[i], thi[i]);
      end
      tick();
      checks++;
      if (result_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL directed_strobe_len[%0d]: rv=%b busy=%b, want 0 0", i, result_valid, busy);
      end
      checks++;
      if (lo_out !== tlo[i] || hi_out !== thi[i]) begin
        errors++;
        $display("FAIL directed_hold[%0d]: lo=%h hi=%h, want lo=%h hi=%h", i, lo_out, hi_out, tlo[i], thi[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int bcnt, rvc;
    logic [31:0] lo, hi;
    for (int s = 0; s < 2; s++) begin
      do_div(1'(s), 32'h1234_5678, 32'd0, bcnt, rvc, lo, hi);
      checks++;
      if (rvc !== 1 || bcnt !== 0) begin
        errors++;
        $display("FAIL divzero_timing[s=%0d]: rv_cycle=%0d busy_cycles=%0d, want 1 0", s, rvc, bcnt);
      end
      checks++;
      if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin
        errors++;
        $display("FAIL divzero_result[s=%0d]: lo=%h hi=%h, want ffffffff 12345678", s, lo, hi);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int bcnt, rvc;
    logic        s;
    logic [31:0] a, b, elo, ehi, lo, hi;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom_range(0, 15);
        1: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      ref_div(s, a, b, elo, ehi);
      do_div(s, a, b, bcnt, rvc, lo, hi);
      checks++;
      if (rvc !== ((b == 32'd0) ? 1 : 33) || bcnt !== ((b == 32'd0) ? 0 : 32)) begin
        errors++;
        $display("FAIL random_timing[%0d]: s=%b a=%h b=%h rv_cycle=%0d busy_cycles=%0d", i, s, a, b, rvc, bcnt);
      end
      checks++;
      if (lo !== elo || hi !== ehi) begin
        errors++;
        $display("FAIL random_result[%0d]: s=%b a=%h b=%h lo=%h hi=%h, want lo=%h hi=%h", i, s, a, b, lo, hi, elo, ehi);
      end
      tick();
    end
  endtask

  task automatic test_cancel();
    int bcnt, rvc, seen_rv;
    logic [31:0] lo, hi;
    do_div(1'b0, 32'd100, 32'd7, bcnt, rvc, lo, hi);
    tick();
    signed_div = 1'b0;
    dividend   = 32'd9;
    divisor    = 32'd3;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL cancel_idle: busy=%b rv=%b, want 0 0", busy, result_valid);
    end
    seen_rv = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid || busy) seen_rv++;
      tick();
    end
    checks++;
    if (seen_rv !== 0) begin
      errors++;
      $display("FAIL cancel_no_result: active cycles=%0d, want 0", seen_rv);
    end
    checks++;
    if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
      errors++;
      $display("FAIL cancel_hold: lo=%h hi=%h, want 0000000e 00000002", lo_out, hi_out);
    end
  endtask

  task automatic test_cancel_start_idle();
    int active;
    signed_div = 1'b0;
    dividend   = 32'd50;
    divisor    = 32'd5;
    start      = 1'b1;
    cancel     = 1'b1;
    tick();
    start  = 1'b0;
    cancel = 1'b0;
    active = 0;
    for (int k = 0; k < 36; k++) begin
      if (busy || result_valid) active++;
      tick();
    end
    checks++;
    if (active !== 0) begin
      errors++;
      $display("FAIL cancel_start_idle: active cycles=%0d, want 0", active);
    end
  endtask

  task automatic test_back_to_back();
    int bcnt, rvc;
    logic [31:0] lo, hi;
    do_div(1'b0, 32'd9, 32'd3, bcnt, rvc, lo, hi);
    checks++;
    if (rvc !== 33 || lo !== 32'd3 || hi !== 32'd0) begin
      errors++;
      $display("FAIL b2b_first: rv_cycle=%0d lo=%h hi=%h, want 33 3 0", rvc, lo, hi);
    end
    // Issued in the DONE cycle of the first divide.
    do_div(1'b0, 32'd10, 32'd4, bcnt, rvc, lo, hi);
    checks++;
    if (rvc !== 33 || bcnt !== 32 || lo !== 32'd2 || hi !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second: rv_cycle=%0d busy_cycles=%0d lo=%h hi=%h, want 33 32 2 2", rvc, bcnt, lo, hi);
    end
    tick();
  endtask

  task automatic test_start_during_calc();
    int rvc;
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    rvc   = -1;
    for (int k = 1; k <= 60; k++) begin
      if (result_valid) begin
        rvc = k;
        break;
      end
      if (k == 5) begin
        start      = 1'b1;
        signed_div = 1'b1;
        dividend   = 32'd5;
        divisor    = 32'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    checks++;
    if (rvc !== 33 || lo_out !== 32'd14 || hi_out !== 32'd2) begin
      errors++;
      $display("FAIL start_in_calc: rv_cycle=%0d lo=%h hi=%h, want 33 0000000e 00000002", rvc, lo_out, hi_out);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int active;
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b rv=%b hi=%h lo=%h, want 0 0 0 0", busy, result_valid, hi_out, lo_out);
    end
    active = 0;
    for (int k = 0; k < 36; k++) begin
      if (busy || result_valid) active++;
      tick();
    end
    checks++;
    if (active !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: active cycles=%0d, want 0", active);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    cancel     = 1'b0;
    signed_div = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;
    #1;
    test_reset();
    test_directed();
    test_div_zero();
    test_random();
    test_cancel();
    test_cancel_start_idle();
    test_back_to_back();
    test_start_during_calc();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 restoring divider that executes MIPS DIV/DIVU for the execute stage. It accepts a start pulse from the pipeline control when a divide is decoded and holds the pipeline via `busy`. It returns quotient (LO) and remainder (HI) with a one-cycle `result_valid` strobe, which the HI/LO register file captures. A `cancel` input aborts an in-flight divide on exception or flush.

## Interface
- No parameters. Operand width is fixed at 32.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a divide; sampled only in IDLE or DONE.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU; captured with `start`.
- `dividend` in 32: rs operand; captured with `start`.
- `divisor` in 32: rt operand; captured with `start`.
- `cancel` in 1: abort the current operation; effective in any state.
- `busy` out 1: high while iterating (CALC).
- `result_valid` out 1: one-cycle strobe; `hi_out`/`lo_out` are valid.
- `hi_out` out 32: remainder.
- `lo_out` out 32: quotient.

## Operation
- States: IDLE, CALC, DONE.
- IDLE/DONE + `start` (no `cancel`):
  - Capture operands and the sign flags `qneg = sgn(a)^sgn(b)` and `rneg = sgn(a)` (signs count only when `signed_div`=1).
  - Convert each operand to a 32-bit unsigned magnitude. abs(0x8000_0000) = 0x8000_0000.
  - Clear the iteration counter.
  - If divisor == 0, go to DONE; otherwise go to CALC.
- CALC, each cycle (32 iterations, counter 0..31):
  - Shift partial remainder left by one, bringing in the next dividend MSB (33-bit remainder register).
  - Trial-subtract the divisor magnitude. If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - Counter == 31 → DONE.
- Entry to DONE (normal):
  - `lo_out` = qneg ? −Q : Q.
  - `hi_out` = rneg ? −R : R (32-bit wrap).
- Entry to DONE (divisor == 0): `lo_out` = 32'hFFFF_FFFF and `hi_out` = raw dividend, for both signed and unsigned.
- DONE: `result_valid`=1 for exactly this cycle.
  - Next state is IDLE, or CALC/DONE if `start` is asserted.
  - `hi_out`/`lo_out` hold until the next entry to DONE.
- `cancel` is asserted in any state:
  - Next state is IDLE and `result_valid` stays 0.
  - `hi_out`/`lo_out` keep their previous values.
  - `cancel` wins over a simultaneous `start`.
- `start` during CALC is ignored. Operand inputs are don't-care except in the `start` cycle.
- Signed overflow: 0x8000_0000 / 0xFFFF_FFFF gives lo = 0x8000_0000, hi = 0. This follows from the wrap rules; no trap.

## Timing
- Reset: state IDLE, `busy`=0, `result_valid`=0, `hi_out`=0, `lo_out`=0, counter 0.
- `start` sampled at edge of cycle N (divisor ≠ 0):
  - `busy`=1 in cycles N+1..N+32.
  - `result_valid`=1 and results valid in cycle N+33.
  - `busy`=0 in N+33.
- Divisor == 0: `result_valid` in cycle N+1; `busy` never asserts.
- Back-to-back: `start` in a DONE cycle (N+33) begins the next divide, so its `busy` starts at N+34.
- Outputs are registered; no combinational path from inputs to outputs.
- `rst` mid-operation returns to the reset state on the next edge regardless of `cancel` or `start`.

## Test plan
- DIVU 100 / 7, `start` at cycle N:
  - `busy` high N+1..N+32.
  - At N+33: `result_valid`=1, lo=14, hi=2.
- DIV −7 / 2 (0xFFFF_FFF9 / 2): lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIV 7 / −2: lo=−3, hi=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0. DIVU 0xFFFF_FFFF / 1 → lo=0xFFFF_FFFF, hi=0.
- Divisor 0, dividend 0x1234_5678, `start` at N → at N+1: `result_valid`=1, lo=0xFFFF_FFFF, hi=0x1234_5678, `busy` stays 0.
- Cancel at N+10 of DIVU 9/3 → IDLE at N+11, no `result_valid`, hi/lo keep their prior values.
- Cancel and `start` together in IDLE → stays IDLE.
- Back-to-back and robustness:
  - `start` in DONE of DIVU 9/3 with new operands 10/4 → second result lo=2, hi=2 exactly 33 cycles later.
  - `start` pulsed during CALC → ignored, first result unchanged.
  - `rst` at N+5 → all outputs 0 at N+6.
